// File: rtl/register_file.sv
// Integer register file with 31 stored registers (x0 hardwired to zero), two
// combinational read ports with same-cycle write bypass, and a commit counter.
module register_file #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   Reg_Write_En_W,
  input  logic [4:0]             RD_Addr_W,
  input  logic [31:0]            Result_W,
  input  logic [4:0]             RS1_Addr_D,
  input  logic [4:0]             RS2_Addr_D,
  output logic [31:0]            RS1_Data_D,
  output logic [31:0]            RS2_Data_D,
  output logic [COUNT_WIDTH-1:0] Write_Count
);

  localparam logic [COUNT_WIDTH-1:0] CountOne = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  logic [31:0] regs [1:31];
  logic        wr_hit;
  logic        commit;

  // Bypass ignores RST so reads during a reset cycle still see the pending write.
  assign wr_hit = Reg_Write_En_W && (RD_Addr_W != 5'd0);
  assign commit = wr_hit && !RST;

  function automatic logic [31:0] read_port(input logic [4:0] addr);
    logic [31:0] data;
    data = 32'h0000_0000;
    if (wr_hit && (addr == RD_Addr_W))
      data = Result_W;
    else if (addr != 5'd0)
      data = regs[addr];
    return data;
  endfunction

  assign RS1_Data_D = read_port(RS1_Addr_D);
  assign RS2_Data_D = read_port(RS2_Addr_D);

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 1; i < 32; i++)
        regs[i] <= 32'h0000_0000;
      Write_Count <= '0;
    end else if (commit) begin
      regs[RD_Addr_W] <= Result_W;
      Write_Count     <= Write_Count + CountOne;
    end
  end

endmodule
